sevenseg_scan: RTL and testbench
================================

Name: sevenseg_scan

Overview:
- Parametrised multiplexed seven-segment display driver for the Nexys-class board top level.
- Generalises the fixed 8-digit AN/CA..CG path: digit count, refresh rate and anode/segment polarity are parameters.
- Adds per-digit enable, decimal points, a raw-segment mode, PWM brightness, an anti-ghosting guard band and tear-free frame-synchronous updates.
- Sits between a memory-mapped register block (software-written shadow values) and the board pins.

Parameters:
- NUM_DIGITS, 8, number of multiplexed digits (1..16).
- CLK_FREQ_HZ, 50_000_000, clk frequency.
- REFRESH_HZ, 1000, full-frame refresh rate.
- BRIGHT_W, 4, brightness field width.
- GUARD, 0, blanked cycles at the start of each digit slot.
- ACTIVE_LOW, 1, 1 = anodes, segments and dp driven low when lit.

Ports:
- clk  in  1  core clock.
- rst  in  1  asynchronous, active-high reset.
- i_load  in  1  single-cycle strobe; captures all i_* display fields into shadow registers.
- i_data  in  4*NUM_DIGITS  hex nibble per digit; digit k = bits [4k+3:4k].
- i_raw  in  7*NUM_DIGITS  raw segment pattern per digit, bit6 = CA .. bit0 = CG, 1 = lit.
- i_mode_raw  in  1  1 = use i_raw, 0 = hex-decode i_data.
- i_digit_en  in  NUM_DIGITS  per-digit enable.
- i_dp  in  NUM_DIGITS  per-digit decimal point, 1 = lit.
- i_brightness  in  BRIGHT_W  0 = dimmest, all ones = brightest.
- o_an  out  NUM_DIGITS  anode drives.
- o_seg  out  7  {CA,CB,CC,CD,CE,CF,CG}.
- o_dp  out  1  decimal point.
- o_frame  out  1  one-cycle pulse per completed frame.

Behaviour:
- Derived constants:
  - TICK = CLK_FREQ_HZ / (REFRESH_HZ*NUM_DIGITS), integer division.
  - Elaboration error if TICK <= GUARD or NUM_DIGITS is outside 1..16.
- Counters:
  - slot_cnt runs 0..TICK-1, then wraps.
  - digit_idx increments on each slot_cnt wrap and wraps from NUM_DIGITS-1 to 0.
- Frame boundary: the cycle where digit_idx = NUM_DIGITS-1 and slot_cnt = TICK-1.
- Shadow registers: on i_load, capture data, raw, mode, digit_en, dp and brightness.
- Active registers:
  - Copied from the shadow registers at each frame boundary, using the shadow values present in that cycle.
  - An i_load in the boundary cycle itself takes effect at the following boundary.
  - Brightness length on_len = ((brightness+1)*(TICK-GUARD)) >> BRIGHT_W, computed at the boundary and held for the whole frame.
- Lit condition: active_en[digit_idx] && GUARD <= slot_cnt < GUARD+on_len. While lit, anode digit_idx is asserted; all other anodes are deasserted.
- Segments:
  - Raw mode: active_raw slice.
  - Hex mode: decoded nibble. Glyphs 0-9 and A,b,C,d,E,F (standard Nexys patterns).
  - Decimal point: active_dp[digit_idx].
  - Segments and dp are forced inactive whenever no anode is lit.
- Output timing:
  - o_an, o_seg and o_dp are registered, one cycle after the counter state that produces them.
  - o_frame is registered and pulses the cycle after each boundary; period = NUM_DIGITS*TICK cycles.
  - Polarity inversion per ACTIVE_LOW is applied at the output registers.
- Reset (async, rst=1):
  - Counters cleared.
  - Shadow and active registers cleared, so all digits are disabled.
  - o_an and o_seg inactive (all ones when ACTIVE_LOW); o_dp inactive; o_frame = 0.
  - Display stays blank until a load followed by a boundary.
  - Reset mid-scan restarts at digit 0, slot 0 with no partial glyph.
- Continuous i_load: the shadow follows the inputs every cycle; active still changes only at boundaries.

Decomposition:
- Package sevenseg_pkg:
  - 16-entry hex-to-segment glyph constant table.
  - seg_t typedef (logic [6:0]).
  - Blank-pattern constant.
- Sub-module sevenseg_hex_dec: combinational nibble -> seg_t lookup via the package table.
- Counters, shadow/active registers and PWM compare stay in sevenseg_scan.

Test Plan:
Bench parameters: NUM_DIGITS=4, CLK_FREQ_HZ=1700, REFRESH_HZ=25 (TICK=17), GUARD=1, BRIGHT_W=4, ACTIVE_LOW=1.
1. Reset: assert rst mid-slot -> o_an=4'b1111, o_seg=7'h7F, o_dp=1, o_frame=0 immediately; after release with no load, the display stays blank for 3 frames.
2. Hex decode: load i_data=16'h1234, en=4'hF, brightness=15, then wait one boundary -> in digit 0's slot, o_an=4'b1110 and o_seg=7'b1001100 (glyph 4) for 16 cycles starting at slot cycle 1. Digit 3 shows glyph 1 (7'b1001111).
3. Brightness: brightness=3 -> each anode is low exactly 4 of 17 cycles per slot; brightness=0 -> 1 cycle; segments inactive outside those windows.
4. Tear-free update: load 16'hFFFF mid-frame -> o_an/o_seg patterns unchanged until the o_frame pulse; new glyphs appear in the next frame. A load in the boundary cycle is deferred one frame.
5. Raw mode, dp and enable: i_mode_raw=1, raw digit1=7'b1111111, dp=4'b0010, en=4'b1011 -> digit 1 shows o_seg=7'h00 with o_dp=0; o_an[2] never goes low.
6. Frame timing: o_frame pulses every 68 cycles, one cycle wide, first pulse 68 cycles after reset release.

Source files
------------

// File: rtl/sevenseg_pkg.sv
// Shared seven-segment types, glyph table and blank pattern.
// Segment order is {CA,CB,CC,CD,CE,CF,CG}; a 1 means the segment is lit, before any output polarity is applied.
package sevenseg_pkg;

    typedef logic [6:0] seg_t;

    localparam seg_t SEG_BLANK = 7'h00;

    // Element 0 is the last entry in the concatenation, so the list runs F down to 0.
    localparam logic [15:0][6:0] GLYPHS = {
        7'h47, // F
        7'h4F, // E
        7'h3D, // d
        7'h4E, // C
        7'h1F, // b
        7'h77, // A
        7'h7B, // 9
        7'h7F, // 8
        7'h70, // 7
        7'h5F, // 6
        7'h5B, // 5
        7'h33, // 4
        7'h79, // 3
        7'h6D, // 2
        7'h30, // 1
        7'h7E  // 0
    };

    function automatic seg_t hex_glyph(input logic [3:0] nib);
        return GLYPHS[nib];
    endfunction

endpackage

// File: rtl/sevenseg_hex_dec.sv
// Combinational hex nibble to seven-segment glyph lookup.
// Zero latency, with no handshake and no backpressure.
module sevenseg_hex_dec
    import sevenseg_pkg::*;
(
    input  logic [3:0] nib,
    output logic [6:0] seg
);

    assign seg = hex_glyph(nib);

endmodule

// File: rtl/sevenseg_scan.sv
// Multiplexed seven-segment scan driver with shadow/active frame-synchronous update, PWM brightness and guard band.
// Outputs are registered one cycle after the counter state that produces them; there is no backpressure.
module sevenseg_scan
    import sevenseg_pkg::*;
#(
    parameter int NUM_DIGITS  = 8,
    parameter int CLK_FREQ_HZ = 50_000_000,
    parameter int REFRESH_HZ  = 1000,
    parameter int BRIGHT_W    = 4,
    parameter int GUARD       = 0,
    parameter int ACTIVE_LOW  = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      i_load,
    input  logic [4*NUM_DIGITS-1:0]   i_data,
    input  logic [7*NUM_DIGITS-1:0]   i_raw,
    input  logic                      i_mode_raw,
    input  logic [NUM_DIGITS-1:0]     i_digit_en,
    input  logic [NUM_DIGITS-1:0]     i_dp,
    input  logic [BRIGHT_W-1:0]       i_brightness,
    output logic [NUM_DIGITS-1:0]     o_an,
    output logic [6:0]                o_seg,
    output logic                      o_dp,
    output logic                      o_frame
);

    localparam int TICK = (NUM_DIGITS > 0 && REFRESH_HZ > 0)
                          ? CLK_FREQ_HZ / (REFRESH_HZ * NUM_DIGITS) : 1;
    localparam int CW   = (TICK > 1) ? $clog2(TICK) : 1;
    localparam int DW   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int OW   = CW + 1;
    localparam int PW   = BRIGHT_W + CW + 1;

    localparam logic [CW-1:0] TICK_M1   = CW'(TICK - 1);
    localparam logic [DW-1:0] LAST_DIG  = DW'(NUM_DIGITS - 1);
    localparam logic [OW-1:0] GUARD_W   = OW'(GUARD);
    localparam logic [PW-1:0] SPAN      = PW'(TICK - GUARD);
    localparam logic          POL       = (ACTIVE_LOW != 0);

    if (TICK <= GUARD || NUM_DIGITS < 1 || NUM_DIGITS > 16) begin : g_param_check
        $error("sevenseg_scan: slot length must exceed GUARD and NUM_DIGITS must be 1..16");
    end

    logic [CW-1:0] slot_cnt;
    logic [DW-1:0] digit_idx;
    logic          boundary;

    logic [4*NUM_DIGITS-1:0] sh_data,  act_data;
    logic [7*NUM_DIGITS-1:0] sh_raw,   act_raw;
    logic                    sh_mode,  act_mode;
    logic [NUM_DIGITS-1:0]   sh_en,    act_en;
    logic [NUM_DIGITS-1:0]   sh_dp,    act_dp;
    logic [BRIGHT_W-1:0]     sh_bright;
    logic [OW-1:0]           on_len;
    logic [OW-1:0]           on_len_nx;
    logic [PW-1:0]           on_prod;

    logic [3:0]            cur_nib;
    seg_t                  cur_raw;
    logic                  cur_en;
    logic                  cur_dp;
    seg_t                  dec_seg;
    logic [OW-1:0]         slot_ext;
    logic                  lit;
    logic [NUM_DIGITS-1:0] an_nx;
    seg_t                  seg_nx;
    logic                  dp_nx;

    assign boundary = (digit_idx == LAST_DIG) && (slot_cnt == TICK_M1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot_cnt  <= '0;
            digit_idx <= '0;
        end else if (slot_cnt == TICK_M1) begin
            slot_cnt  <= '0;
            digit_idx <= (digit_idx == LAST_DIG) ? '0 : digit_idx + DW'(1);
        end else begin
            slot_cnt  <= slot_cnt + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh_data   <= '0;
            sh_raw    <= '0;
            sh_mode   <= 1'b0;
            sh_en     <= '0;
            sh_dp     <= '0;
            sh_bright <= '0;
        end else if (i_load) begin
            sh_data   <= i_data;
            sh_raw    <= i_raw;
            sh_mode   <= i_mode_raw;
            sh_en     <= i_digit_en;
            sh_dp     <= i_dp;
            sh_bright <= i_brightness;
        end
    end

    // On-time scales the unguarded part of the slot by (brightness+1)/2^BRIGHT_W.
    assign on_prod   = (PW'(sh_bright) + PW'(1)) * SPAN;
    assign on_len_nx = OW'(on_prod >> BRIGHT_W);

    // The active copy reads the shadow as it stands before any same-cycle load, so a load on the boundary waits a frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            act_data <= '0;
            act_raw  <= '0;
            act_mode <= 1'b0;
            act_en   <= '0;
            act_dp   <= '0;
            on_len   <= '0;
        end else if (boundary) begin
            act_data <= sh_data;
            act_raw  <= sh_raw;
            act_mode <= sh_mode;
            act_en   <= sh_en;
            act_dp   <= sh_dp;
            on_len   <= on_len_nx;
        end
    end

    always_comb begin
        cur_nib = '0;
        cur_raw = SEG_BLANK;
        cur_en  = 1'b0;
        cur_dp  = 1'b0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (digit_idx == DW'(k)) begin
                cur_nib = act_data[4*k +: 4];
                cur_raw = act_raw[7*k +: 7];
                cur_en  = act_en[k];
                cur_dp  = act_dp[k];
            end
        end
    end

    sevenseg_hex_dec u_hex_dec (
        .nib (cur_nib),
        .seg (dec_seg)
    );

    assign slot_ext = {1'b0, slot_cnt};
    assign lit      = cur_en && (slot_ext >= GUARD_W) && (slot_ext < GUARD_W + on_len);

    always_comb begin
        an_nx = '0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            an_nx[k] = lit && (digit_idx == DW'(k));
        end
        seg_nx = lit ? (act_mode ? cur_raw : dec_seg) : SEG_BLANK;
        dp_nx  = lit && cur_dp;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_an    <= {NUM_DIGITS{POL}};
            o_seg   <= {7{POL}};
            o_dp    <= POL;
            o_frame <= 1'b0;
        end else begin
            o_an    <= an_nx ^ {NUM_DIGITS{POL}};
            o_seg   <= seg_nx ^ {7{POL}};
            o_dp    <= dp_nx ^ POL;
            o_frame <= boundary;
        end
    end

endmodule

// File: tb/tb_sevenseg_scan.sv
// Directed bench for sevenseg_scan with a cycle scoreboard: 4 digits, 17-cycle slots, 1-cycle guard, active-low.
module tb_sevenseg_scan;

    localparam int N      = 4;
    localparam int TICK   = 17;
    localparam int GUARD  = 1;
    localparam int BW     = 4;
    localparam int FRAME  = N * TICK;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_load;
    logic [15:0] i_data;
    logic [27:0] i_raw;
    logic        i_mode_raw;
    logic [3:0]  i_digit_en;
    logic [3:0]  i_dp;
    logic [3:0]  i_brightness;
    logic [3:0]  o_an;
    logic [6:0]  o_seg;
    logic        o_dp;
    logic        o_frame;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
        logic       frame;
    } out_t;

    out_t exp_q[$];

    int          m_slot, m_dig, m_on, cyc, last_frame;
    logic [15:0] sh_data, ac_data;
    logic [27:0] sh_raw, ac_raw;
    logic        sh_mode, ac_mode;
    logic [3:0]  sh_en, ac_en, sh_dp, ac_dp, sh_br;

    sevenseg_scan #(
        .NUM_DIGITS  (N),
        .CLK_FREQ_HZ (1700),
        .REFRESH_HZ  (25),
        .BRIGHT_W    (BW),
        .GUARD       (GUARD),
        .ACTIVE_LOW  (1)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .i_load       (i_load),
        .i_data       (i_data),
        .i_raw        (i_raw),
        .i_mode_raw   (i_mode_raw),
        .i_digit_en   (i_digit_en),
        .i_dp         (i_dp),
        .i_brightness (i_brightness),
        .o_an         (o_an),
        .o_seg        (o_seg),
        .o_dp         (o_dp),
        .o_frame      (o_frame)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] ref_glyph(input logic [3:0] n);
        case (n)
            4'h0: return 7'b1111110;
            4'h1: return 7'b0110000;
            4'h2: return 7'b1101101;
            4'h3: return 7'b1111001;
            4'h4: return 7'b0110011;
            4'h5: return 7'b1011011;
            4'h6: return 7'b1011111;
            4'h7: return 7'b1110000;
            4'h8: return 7'b1111111;
            4'h9: return 7'b1111011;
            4'hA: return 7'b1110111;
            4'hB: return 7'b0011111;
            4'hC: return 7'b1001110;
            4'hD: return 7'b0111101;
            4'hE: return 7'b1001111;
            default: return 7'b1000111;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_slot = 0; m_dig = 0; m_on = 0; cyc = 0; last_frame = 0;
        sh_data = '0; ac_data = '0; sh_raw = '0; ac_raw = '0;
        sh_mode = 1'b0; ac_mode = 1'b0; sh_en = '0; ac_en = '0;
        sh_dp = '0; ac_dp = '0; sh_br = '0;
        exp_q.delete();
    endtask

    // Predict the output of the coming edge, advance the model, clock, then compare.
    task automatic cycle();
        out_t e;
        out_t got;
        logic lit;
        lit = ac_en[m_dig] && (m_slot >= GUARD) && (m_slot < GUARD + m_on);
        e.an  = 4'hF;
        e.seg = 7'h7F;
        e.dp  = 1'b1;
        if (lit) begin
            e.an[m_dig] = 1'b0;
            e.seg = ~(ac_mode ? ac_raw[m_dig*7 +: 7] : ref_glyph(ac_data[m_dig*4 +: 4]));
            e.dp  = ~ac_dp[m_dig];
        end
        e.frame = (m_dig == N - 1) && (m_slot == TICK - 1);
        exp_q.push_back(e);
        if (e.frame) begin
            ac_data = sh_data; ac_raw = sh_raw; ac_mode = sh_mode;
            ac_en = sh_en; ac_dp = sh_dp;
            m_on = ((int'(sh_br) + 1) * (TICK - GUARD)) >> BW;
        end
        if (i_load) begin
            sh_data = i_data; sh_raw = i_raw; sh_mode = i_mode_raw;
            sh_en = i_digit_en; sh_dp = i_dp; sh_br = i_brightness;
        end
        if (m_slot == TICK - 1) begin
            m_slot = 0;
            m_dig  = (m_dig + 1) % N;
        end else begin
            m_slot++;
        end
        @(posedge clk);
        #1;
        cyc++;
        got = exp_q.pop_front();
        check("scan", {o_an, o_seg, o_dp, o_frame}, got);
        if (o_frame) begin
            check("frame_period", cyc - last_frame, FRAME);
            last_frame = cyc;
        end
    endtask

    task automatic do_load(input logic [15:0] d, input logic [27:0] r, input logic m,
                           input logic [3:0] en, input logic [3:0] dp, input logic [3:0] br);
        i_data = d; i_raw = r; i_mode_raw = m; i_digit_en = en; i_dp = dp; i_brightness = br;
        i_load = 1'b1;
        cycle();
        i_load = 1'b0;
    endtask

    task automatic wait_frame();
        int n;
        n = 0;
        do begin
            cycle();
            n++;
        end while (!o_frame && n < 3 * FRAME);
        check("frame_seen", o_frame, 1'b1);
    endtask

    initial begin
        int hits, bad;
        int lowc[N];

        rst = 1'b1; i_load = 1'b0; i_data = '0; i_raw = '0; i_mode_raw = 1'b0;
        i_digit_en = '0; i_dp = '0; i_brightness = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("rst_an", o_an, 4'hF);
        check("rst_seg", o_seg, 7'h7F);
        check("rst_dp", o_dp, 1'b1);
        check("rst_frame", o_frame, 1'b0);
        rst = 1'b0;

        // Blank for three frames with no load; first frame pulse 68 cycles after release.
        hits = 0;
        repeat (3 * FRAME) begin
            cycle();
            if (o_an !== 4'hF) hits++;
        end
        check("blank_after_reset", hits, 0);

        // Hex decode at full brightness.
        do_load(16'h1234, 28'h0, 1'b0, 4'hF, 4'h0, 4'd15);
        wait_frame();
        cycle();
        check("hex_guard_slot", o_an, 4'hF);
        hits = 0;
        repeat (16) begin
            cycle();
            if (o_an === 4'b1110 && o_seg === 7'b1001100) hits++;
        end
        check("hex_digit0_glyph4", hits, 16);
        repeat (2 * TICK) cycle();
        cycle();
        hits = 0;
        repeat (16) begin
            cycle();
            if (o_an === 4'b0111 && o_seg === 7'b1001111) hits++;
        end
        check("hex_digit3_glyph1", hits, 16);

        // Brightness 3 then 0: on-time per slot and blanking outside the window.
        for (int b = 0; b < 2; b++) begin
            do_load(16'h1234, 28'h0, 1'b0, 4'hF, 4'h0, (b == 0) ? 4'd3 : 4'd0);
            wait_frame();
            for (int k = 0; k < N; k++) lowc[k] = 0;
            bad = 0;
            repeat (FRAME) begin
                cycle();
                for (int k = 0; k < N; k++) if (o_an[k] === 1'b0) lowc[k]++;
                if (o_an === 4'hF && (o_seg !== 7'h7F || o_dp !== 1'b1)) bad++;
            end
            for (int k = 0; k < N; k++) check("bright_on_cycles", lowc[k], (b == 0) ? 4 : 1);
            check("bright_blank_segs", bad, 0);
        end

        // Tear-free update: mid-frame load becomes visible only after the frame pulse.
        do_load(16'h1234, 28'h0, 1'b0, 4'hF, 4'h0, 4'd15);
        wait_frame();
        repeat (20) cycle();
        do_load(16'hFFFF, 28'h0, 1'b0, 4'hF, 4'h0, 4'd15);
        hits = 0;
        bad = 0;
        do begin
            cycle();
            bad++;
            if (o_seg === 7'b0111000) hits++;
        end while (!o_frame && bad < 2 * FRAME);
        check("tear_old_frame_no_F", hits, 0);
        hits = 0;
        repeat (FRAME) begin
            cycle();
            if (o_seg === 7'b0111000) hits++;
        end
        check("tear_new_frame_F", hits, 64);

        // Load landing on the boundary cycle is deferred by one frame.
        repeat (FRAME - 1) cycle();
        do_load(16'h0000, 28'h0, 1'b0, 4'hF, 4'h0, 4'd15);
        check("bnd_load_on_pulse", o_frame, 1'b1);
        hits = 0;
        repeat (FRAME) begin
            cycle();
            if (o_seg === 7'b0111000) hits++;
        end
        check("bnd_load_deferred", hits, 64);
        hits = 0;
        repeat (FRAME) begin
            cycle();
            if (o_seg === 7'b0000001) hits++;
        end
        check("bnd_load_applied", hits, 64);

        // Raw mode, decimal point and per-digit enable.
        do_load(16'h0000, 28'h0003F81, 1'b1, 4'b1011, 4'b0010, 4'd15);
        wait_frame();
        hits = 0;
        bad = 0;
        repeat (FRAME) begin
            cycle();
            if (o_an === 4'b1101 && o_seg === 7'h00 && o_dp === 1'b0) hits++;
            if (o_an[2] === 1'b0) bad++;
        end
        check("raw_digit1_all_lit_dp", hits, 16);
        check("raw_digit2_disabled", bad, 0);

        // Reset in the middle of a lit slot.
        repeat (25) cycle();
        check("pre_reset_lit", o_an, 4'b1101);
        #3;
        rst = 1'b1;
        #1;
        check("mid_rst_an", o_an, 4'hF);
        check("mid_rst_seg", o_seg, 7'h7F);
        check("mid_rst_dp", o_dp, 1'b1);
        check("mid_rst_frame", o_frame, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        hits = 0;
        repeat (3 * FRAME) begin
            cycle();
            if (o_an !== 4'hF) hits++;
        end
        check("blank_after_mid_reset", hits, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
